// File: rtl/imm_decode_queue.sv
// Instruction queue that decodes the RISC-V immediate/format on entry and presents them at the head.
// Optional macro IMM_DECODE_CSR_ZIMM_EN adds the CSR zero-extended uimm (Z) format.
module imm_decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   typedef enum logic [2:0] {
      FMT_NONE    = 3'd0,
      FMT_I       = 3'd1,
      FMT_S       = 3'd2,
      FMT_B       = 3'd3,
      FMT_U       = 3'd4,
      FMT_J       = 3'd5,
      FMT_Z       = 3'd6,
      FMT_ILLEGAL = 3'd7
   } fmt_e;

   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic            dec_illegal;

   logic [31:0]     mem_instr   [DEPTH];
   logic [XLEN-1:0] mem_imm     [DEPTH];
   fmt_e            mem_fmt     [DEPTH];
   logic            mem_illegal [DEPTH];

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;
   logic            push;
   logic            pop;

   // Anything not matched below (including low bits != 2'b11) stays illegal with a zero immediate.
   always_comb begin
      dec_imm     = '0;
      dec_fmt     = FMT_ILLEGAL;
      dec_illegal = 1'b1;
      case (in_instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
            dec_imm     = XLEN'($signed(in_instr[31:20]));
            dec_fmt     = FMT_I;
            dec_illegal = 1'b0;
         end
         7'b1110011: begin
            dec_illegal = 1'b0;
`ifdef IMM_DECODE_CSR_ZIMM_EN
            if (in_instr[14]) begin
               dec_imm = XLEN'(in_instr[19:15]);
               dec_fmt = FMT_Z;
            end else begin
               dec_imm = XLEN'($signed(in_instr[31:20]));
               dec_fmt = FMT_I;
            end
`else
            dec_imm = XLEN'($signed(in_instr[31:20]));
            dec_fmt = FMT_I;
`endif
         end
         7'b0100011: begin
            dec_imm     = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            dec_fmt     = FMT_S;
            dec_illegal = 1'b0;
         end
         7'b1100011: begin
            dec_imm     = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
            dec_fmt     = FMT_B;
            dec_illegal = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            dec_imm     = XLEN'($signed({in_instr[31:12], 12'b0}));
            dec_fmt     = FMT_U;
            dec_illegal = 1'b0;
         end
         7'b1101111: begin
            dec_imm     = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
            dec_fmt     = FMT_J;
            dec_illegal = 1'b0;
         end
         7'b0110011: begin
            dec_fmt     = FMT_NONE;
            dec_illegal = 1'b0;
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               dec_imm     = XLEN'($signed(in_instr[31:20]));
               dec_fmt     = FMT_I;
               dec_illegal = 1'b0;
            end
         end
         7'b0111011: begin
            if (XLEN == 64) begin
               dec_fmt     = FMT_NONE;
               dec_illegal = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   assign in_ready  = (count < FULL_COUNT);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Storage needs no reset: entries are only visible through the pointers and count.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem_instr[wr_ptr]   <= in_instr;
         mem_imm[wr_ptr]     <= dec_imm;
         mem_fmt[wr_ptr]     <= dec_fmt;
         mem_illegal[wr_ptr] <= dec_illegal;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      out_instr   = '0;
      out_imm     = '0;
      out_fmt     = 3'd0;
      out_illegal = 1'b0;
      if (out_valid) begin
         out_instr   = mem_instr[rd_ptr];
         out_imm     = mem_imm[rd_ptr];
         out_fmt     = mem_fmt[rd_ptr];
         out_illegal = mem_illegal[rd_ptr];
      end
   end

endmodule
